// File: rtl/aes_stream_sequencer.sv
// -----------------------------------------------------------------------------
// aes_stream_sequencer
//
// Purpose:
//   Streaming front-end for the AES-256 register driver. It accepts a 256-bit
//   key (8 words) and 128-bit plaintext blocks (4 words) on 32-bit valid/ready
//   streams. It writes them into the driver's register map and issues a
//   one-cycle start pulse. It waits for a rising edge of the driver's done flag,
//   then reads the four ciphertext words back out as a 32-bit valid/ready stream.
//
// Handshake semantics (all three streams):
//   A word transfers on a rising clk edge where valid && ready are both high.
//   The source may raise valid at any time, and must hold data stable while
//   valid && !ready. This block never drops ct_valid without a transfer, except
//   on reset.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   key_data/valid/ready   key words, MSW (key[255:224]) first
//   pt_data/valid/ready    plaintext words, MSW first
//   ct_data/valid/ready    ciphertext words, MSW first (registered)
//   drv_data_in, drv_write_addr, drv_write_en
//                          driver register writes (addr 0-7 key, 8-11 plaintext)
//   drv_start_cmd          one-cycle start pulse to the driver
//   drv_done_flag          driver done level (completion is its rising edge)
//   drv_data_out           driver read data, combinational on drv_read_addr
//   drv_read_addr          driver ciphertext word select
//   key_loaded             a full key has been written since reset
//   timeout_err            sticky WAIT timeout flag, cleared only by reset
//   blk_count              blocks delivered (only with AES_SEQ_BLKCNT_EN)
//   dbg_state              current FSM state, for debug/checkers
//
// Configuration:
//   Define AES_SEQ_BLKCNT_EN to add the 32-bit blk_count output. The counter
//   wraps, and a block that times out does not increment it.
// -----------------------------------------------------------------------------
module aes_stream_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] key_data,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [31:0] pt_data,
  input  logic        pt_valid,
  output logic        pt_ready,
  output logic [31:0] ct_data,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic [31:0] drv_data_in,
  output logic [3:0]  drv_write_addr,
  output logic        drv_write_en,
  output logic        drv_start_cmd,
  input  logic        drv_done_flag,
  input  logic [31:0] drv_data_out,
  output logic [1:0]  drv_read_addr,
  output logic        key_loaded,
  output logic        timeout_err,
`ifdef AES_SEQ_BLKCNT_EN
  output logic [31:0] blk_count,
`endif
  output logic [2:0]  dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEY   = 3'd1;
  localparam logic [2:0] S_PT    = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;
  localparam logic [2:0] S_OUT   = 3'd6;

  logic [2:0]    r_state;
  logic [2:0]    r_cnt;        // word index inside a key (0-7) or block (0-3)
  logic          r_key_loaded;
  logic          r_timeout_err;
  logic          r_done_prev;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_rd_addr;
  logic [31:0]   r_ct_data;
  logic          r_ct_valid;
`ifdef AES_SEQ_BLKCNT_EN
  logic [31:0]   r_blk_count;
`endif

  logic          w_key_hs;
  logic          w_pt_hs;
  logic          w_done_rise;
  logic [TW-1:0] w_timer_next;

  // Both ready outputs are forced low while reset is asserted, so that every
  // output reads 0 during reset and no write can slip through.
  // In IDLE a pending key word wins, so pt_ready stays low while key_valid is high.
  assign key_ready = !reset && ((r_state == S_IDLE) || (r_state == S_KEY));
  assign pt_ready  = !reset && (((r_state == S_IDLE) && r_key_loaded && !key_valid) ||
                                (r_state == S_PT));

  assign w_key_hs = key_valid && key_ready;
  assign w_pt_hs  = pt_valid && pt_ready;

  // The driver is written in the same cycle as the stream handshake. r_cnt
  // is 0 whenever the FSM sits in IDLE, so the first word lands at 0 or 8.
  assign drv_write_en   = w_key_hs || w_pt_hs;
  assign drv_write_addr = w_key_hs ? {1'b0, r_cnt} :
                          w_pt_hs  ? {2'b10, r_cnt[1:0]} : 4'd0;
  assign drv_data_in    = w_key_hs ? key_data :
                          w_pt_hs  ? pt_data  : 32'd0;

  assign drv_start_cmd = !reset && (r_state == S_START);
  assign drv_read_addr = r_rd_addr;

  // A done level that is still high from the previous block is not a
  // completion; only a fresh 0->1 transition counts.
  assign w_done_rise  = drv_done_flag && !r_done_prev;
  assign w_timer_next = r_timer + TW'(1);

  assign ct_data     = r_ct_data;
  assign ct_valid    = r_ct_valid;
  assign key_loaded  = r_key_loaded;
  assign timeout_err = r_timeout_err;
  assign dbg_state   = r_state;
`ifdef AES_SEQ_BLKCNT_EN
  assign blk_count   = r_blk_count;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 3'd0;
      r_key_loaded  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_done_prev   <= 1'b0;
      r_timer       <= '0;
      r_rd_addr     <= 2'd0;
      r_ct_data     <= 32'd0;
      r_ct_valid    <= 1'b0;
`ifdef AES_SEQ_BLKCNT_EN
      r_blk_count   <= 32'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_key_hs) begin
            r_cnt   <= 3'd1;
            r_state <= S_KEY;
          end else if (w_pt_hs) begin
            r_cnt   <= 3'd1;
            r_state <= S_PT;
          end
        end

        S_KEY: begin
          if (w_key_hs) begin
            if (r_cnt == 3'd7) begin
              r_cnt        <= 3'd0;
              r_key_loaded <= 1'b1;
              r_state      <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end

        S_PT: begin
          if (w_pt_hs) begin
            if (r_cnt == 3'd3) begin
              r_cnt   <= 3'd0;
              r_state <= S_START;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end

        S_START: begin
          r_done_prev <= drv_done_flag;
          r_timer     <= '0;
          r_state     <= S_WAIT;
        end

        S_WAIT: begin
          r_done_prev <= drv_done_flag;
          if (w_done_rise) begin
            r_rd_addr <= 2'd0;
            r_state   <= S_READ;
          end else if (w_timer_next == TIMEOUT_VAL) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= w_timer_next;
          end
        end

        S_READ: begin
          r_ct_data  <= drv_data_out;
          r_ct_valid <= 1'b1;
          r_state    <= S_OUT;
        end

        S_OUT: begin
          // ct_valid is only ever high here, so ct_ready alone marks the transfer.
          // Dropping valid for the READ bubble prevents a word from being taken twice.
          if (ct_ready) begin
            r_ct_valid <= 1'b0;
            if (r_rd_addr == 2'd3) begin
              r_rd_addr <= 2'd0;
              r_state   <= S_IDLE;
`ifdef AES_SEQ_BLKCNT_EN
              r_blk_count <= r_blk_count + 32'd1;
`endif
            end else begin
              r_rd_addr <= r_rd_addr + 2'd1;
              r_state   <= S_READ;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_stream_sequencer
//
// Drives key/plaintext streams into aes_stream_sequencer. A register-level
// stand-in for the AES driver computes a ciphertext from whatever was written
// into its registers, and asserts done after a fixed latency. The bench's
// expected ciphertext comes from the words it sent and the same cipher rule.
// For the FIPS-197 C.3 key/plaintext the rule returns the published
// ciphertext. Any other input gets a cheap mixing function.
// -----------------------------------------------------------------------------
module tb_aes_stream_sequencer;

  localparam int TIMEOUT = 1024;
  localparam int LAT     = 12;

  localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] key_data, pt_data, ct_data, drv_data_in, drv_data_out;
  logic        key_valid, key_ready, pt_valid, pt_ready, ct_valid, ct_ready;
  logic [3:0]  drv_write_addr;
  logic        drv_write_en, drv_start_cmd, drv_done_flag;
  logic [1:0]  drv_read_addr;
  logic        key_loaded, timeout_err;
  logic [2:0]  dbg_state;
`ifdef AES_SEQ_BLKCNT_EN
  logic [31:0] blk_count;
`endif

  aes_stream_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .drv_data_in(drv_data_in), .drv_write_addr(drv_write_addr),
    .drv_write_en(drv_write_en), .drv_start_cmd(drv_start_cmd),
    .drv_done_flag(drv_done_flag), .drv_data_out(drv_data_out),
    .drv_read_addr(drv_read_addr),
    .key_loaded(key_loaded), .timeout_err(timeout_err),
`ifdef AES_SEQ_BLKCNT_EN
    .blk_count(blk_count),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0]  exp_q[$];
  logic [255:0] cur_key;
  int exp_writes = 0;
  int exp_blk = 0;

  // Cipher rule used by the driver stand-in and by the expectation side.
  function automatic logic [31:0] model_ct(input logic [255:0] k, input logic [127:0] p, input int i);
    logic [127:0] c;
    logic [31:0]  kw, kw2, pw;
    c = FIPS_CT;
    if (k == FIPS_KEY && p == FIPS_PT) return 32'(c >> (32 * (3 - i)));
    kw  = 32'(k >> (32 * (7 - i)));
    kw2 = 32'(k >> (32 * (3 - i)));
    pw  = 32'(p >> (32 * (3 - i)));
    return pw ^ kw ^ {kw2[15:0], kw2[31:16]} ^ (32'h9e3779b9 * 32'(i + 1));
  endfunction

  // ---------------- driver stand-in ----------------
  // done_mode 0: done drops at start and rises after LAT cycles.
  // done_mode 1: done stays high for a few cycles after start, then drops, then rises.
  // done_mode 2: done never rises.
  int           done_mode = 0;
  logic [255:0] key_r;
  logic [127:0] pt_r;
  logic [31:0]  out_r[4];
  logic         done_r;
  logic         busy;
  int           lat_cnt;

  assign drv_done_flag = done_r;
  assign drv_data_out  = out_r[drv_read_addr];

  always @(posedge clk) begin
    if (reset) begin
      done_r  <= 1'b0;
      busy    <= 1'b0;
      lat_cnt <= 0;
    end else begin
      if (drv_write_en) begin
        if (drv_write_addr < 4'd8)
          key_r[(7 - int'(drv_write_addr)) * 32 +: 32] <= drv_data_in;
        else if (drv_write_addr < 4'd12)
          pt_r[(11 - int'(drv_write_addr)) * 32 +: 32] <= drv_data_in;
      end
      if (drv_start_cmd) begin
        busy    <= (done_mode != 2);
        lat_cnt <= 0;
        if (done_mode != 1) done_r <= 1'b0;
      end else if (busy) begin
        lat_cnt <= lat_cnt + 1;
        if (done_mode == 1 && lat_cnt == 4) done_r <= 1'b0;
        if (lat_cnt == LAT) begin
          done_r <= 1'b1;
          busy   <= 1'b0;
          for (int i = 0; i < 4; i++) out_r[i] <= model_ct(key_r, pt_r, i);
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  int write_cnt = 0, start_cnt = 0, ct_hs_cnt = 0, ct_valid_cnt = 0, bad_write = 0;
  always @(posedge clk) begin
    if (drv_write_en) begin
      write_cnt++;
      if (busy || ct_valid || drv_write_addr > 4'd11) bad_write++;
    end
    if (drv_start_cmd) start_cnt++;
    if (ct_valid && ct_ready) ct_hs_cnt++;
    if (ct_valid) ct_valid_cnt++;
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a rising edge (posedge + #1).
  task automatic send_word(input bit is_key, input logic [31:0] d);
    int n;
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin @(posedge clk); #1; end
    if (is_key) begin key_data = d; key_valid = 1'b1; end
    else        begin pt_data  = d; pt_valid  = 1'b1; end
    n = 0;
    @(negedge clk);
    while (!(is_key ? key_ready : pt_ready) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!(is_key ? key_ready : pt_ready)) begin
      errors++;
      $display("FAIL %s_handshake: ready stayed 0 for 100 cycles, required 1", is_key ? "key" : "pt");
    end else begin
      exp_writes++;
    end
    @(posedge clk); #1;
    if (is_key) begin key_valid = 1'b0; key_data = $urandom; end
    else        begin pt_valid  = 1'b0; pt_data  = $urandom; end
  endtask

  task automatic load_key(input logic [255:0] k);
    for (int i = 0; i < 8; i++) send_word(1'b1, 32'(k >> (32 * (7 - i))));
    cur_key = k;
  endtask

  task automatic run_block(input logic [127:0] p, input int stall_word, input int stall_len);
    int s0, h0, n, stall;
    bit alive, stable;
    logic [31:0] held, exp;
    s0 = start_cnt;
    h0 = ct_hs_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(model_ct(cur_key, p, i));
    for (int i = 0; i < 4; i++) send_word(1'b0, 32'(p >> (32 * (3 - i))));
    alive = 1'b1;
    for (int i = 0; i < 4 && alive; i++) begin
      n = 0;
      @(negedge clk);
      while (!ct_valid && n < 300) begin @(negedge clk); n++; end
      checks++;
      if (!ct_valid) begin
        errors++;
        alive = 1'b0;
        $display("FAIL ct_wait word %0d: ct_valid=0 after 300 cycles, required 1", i);
        exp_q.delete();
      end else begin
        held   = ct_data;
        stable = 1'b1;
        stall  = (i == stall_word) ? stall_len : int'($urandom_range(0, 2));
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          if (ct_valid !== 1'b1 || ct_data !== held) stable = 1'b0;
        end
        if (stall > 0) begin
          checks++;
          if (!stable) begin
            errors++;
            $display("FAIL ct_hold word %0d: valid=%b data=%h, required valid=1 data=%h", i, ct_valid, ct_data, held);
          end
        end
        ct_ready = 1'b1;
        @(posedge clk); #1;
        ct_ready = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (held !== exp) begin
          errors++;
          $display("FAIL ct_word %0d: got %h, required %h", i, held, exp);
        end
      end
    end
    exp_blk++;
    checks++;
    if (start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL start_pulses: got %0d, required 1", start_cnt - s0);
    end
    checks++;
    if (ct_hs_cnt - h0 != 4) begin
      errors++;
      $display("FAIL ct_transfers: got %0d, required 4", ct_hs_cnt - h0);
    end
`ifdef AES_SEQ_BLKCNT_EN
    checks++;
    if (blk_count !== 32'(exp_blk)) begin
      errors++;
      $display("FAIL blk_count: got %0d, required %0d", blk_count, exp_blk);
    end
`endif
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({ct_valid, drv_write_en, drv_start_cmd, key_loaded, timeout_err, key_ready, pt_ready} !== 7'd0 ||
        ct_data !== 32'd0 || drv_data_in !== 32'd0 || drv_write_addr !== 4'd0 || drv_read_addr !== 2'd0) begin
      errors++;
      $display("FAIL %s_outputs: ctv=%b we=%b st=%b kl=%b to=%b kr=%b pr=%b ct=%h din=%h wa=%h ra=%h, required all 0",
               tag, ct_valid, drv_write_en, drv_start_cmd, key_loaded, timeout_err, key_ready, pt_ready,
               ct_data, drv_data_in, drv_write_addr, drv_read_addr);
    end
`ifdef AES_SEQ_BLKCNT_EN
    checks++;
    if (blk_count !== 32'd0) begin
      errors++;
      $display("FAIL %s_blk_count: got %0d, required 0", tag, blk_count);
    end
`endif
  endtask

  // Holds pt_valid high for a while and checks that it is never accepted.
  task automatic check_pt_blocked(input string tag);
    int w0;
    bit seen;
    w0 = write_cnt;
    seen = 1'b0;
    pt_data  = $urandom;
    pt_valid = 1'b1;
    repeat (10) begin @(negedge clk); if (pt_ready) seen = 1'b1; end
    @(posedge clk); #1;
    pt_valid = 1'b0;
    checks++;
    if (seen) begin errors++; $display("FAIL %s_pt_ready: got 1 without a key, required 0", tag); end
    checks++;
    if (write_cnt != w0) begin errors++; $display("FAIL %s_writes: got %0d, required 0", tag, write_cnt - w0); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || pt_ready !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_ready: key_ready=%b pt_ready=%b state=%0d, required 1 0 0", key_ready, pt_ready, dbg_state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pt_before_key();
    check_pt_blocked("no_key");
    load_key(FIPS_KEY);
    checks++;
    if (key_loaded !== 1'b1) begin errors++; $display("FAIL key_loaded: got %b, required 1", key_loaded); end
  endtask

  task automatic test_fips_stall();
    done_mode = 0;
    run_block(FIPS_PT, 1, 20);
  endtask

  task automatic test_back_to_back();
    logic [255:0] k;
    logic [127:0] p1, p2;
    k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    p1 = {$urandom, $urandom, $urandom, $urandom};
    p2 = {$urandom, $urandom, $urandom, $urandom};
    load_key(k);
    done_mode = 0;
    run_block(p1, -1, 0);
    done_mode = 1;
    run_block(p2, -1, 0);
    done_mode = 0;
  endtask

  task automatic test_timeout();
    int n, v0, b0;
    logic [127:0] p;
    v0 = ct_valid_cnt;
    b0 = exp_blk;
    done_mode = 2;
    p = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) send_word(1'b0, 32'(p >> (32 * (3 - i))));
    n = 0;
    @(negedge clk);
    while (!drv_start_cmd && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!drv_start_cmd) begin errors++; $display("FAIL timeout_start: no start pulse, required 1"); end
    n = 0;
    while (!timeout_err && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n < TIMEOUT || n > TIMEOUT + 2) begin
      errors++;
      $display("FAIL timeout_delay: timeout_err after %0d cycles (err=%b), required %0d..%0d", n, timeout_err, TIMEOUT, TIMEOUT + 2);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ct_valid_cnt != v0 || dbg_state !== 3'd0 || key_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_idle: ct_valid cycles=%0d state=%0d key_ready=%b, required 0 0 1", ct_valid_cnt - v0, dbg_state, key_ready);
    end
`ifdef AES_SEQ_BLKCNT_EN
    checks++;
    if (blk_count !== 32'(b0)) begin errors++; $display("FAIL timeout_blk_count: got %0d, required %0d", blk_count, b0); end
`endif
    @(posedge clk); #1;
    done_mode = 0;
    run_block({$urandom, $urandom, $urandom, $urandom}, -1, 0);
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b, required 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] p;
    p = {$urandom, $urandom, $urandom, $urandom};
    send_word(1'b0, p[127:96]);
    send_word(1'b0, p[95:64]);
    pt_data  = p[63:32];
    pt_valid = 1'b1;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk); #1;
    reset    = 1'b0;
    pt_valid = 1'b0;
    exp_blk  = 0;
    check_pt_blocked("after_reset");
    load_key(FIPS_KEY);
    run_block(FIPS_PT, -1, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      load_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      for (int b = 0; b < 2; b++) begin
        done_mode = int'($urandom_range(0, 1));
        run_block({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      end
    end
    done_mode = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    key_valid = 1'b0; pt_valid = 1'b0; ct_ready = 1'b0;
    key_data  = 32'd0; pt_data = 32'd0;
    reset     = 1'b1;
    test_reset();
    test_pt_before_key();
    test_fips_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    repeat (4) @(posedge clk);
    checks++;
    if (write_cnt != exp_writes) begin errors++; $display("FAIL write_count: got %0d, required %0d", write_cnt, exp_writes); end
    checks++;
    if (bad_write != 0) begin errors++; $display("FAIL stray_writes: got %0d, required 0", bad_write); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected: got %0d, required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
